countdown_seconds_timer: RTL and testbench
==========================================

// Module: countdown_seconds_timer
// PURPOSE
//  Game countdown timer that sits directly upstream of the 4-digit seven-segment driver.
//  Divides clk down to a 1 Hz tick and counts START_SECS down to 0.
//  display_value feeds the driver's displayNumber input.
//  Start, pause and clear come from debounced single-cycle button pulses; done and expired go to game control.
// PARAMETERS
//  CLK_HZ      100_000_000  clk cycles per second tick; legal range >= 2
//  START_SECS  99           reload value in seconds; legal range 1..9999
// PORTS
//  clk            in   1   system clock; all logic on posedge
//  reset          in   1   asynchronous, active-low reset
//  start          in   1   1-cycle pulse: load START_SECS and run
//  pause          in   1   1-cycle pulse: toggle RUN <-> PAUSE
//  clear          in   1   1-cycle pulse: return to IDLE
//  display_value  out  16  remaining seconds, binary 0..9999
//  running        out  1   high while state==RUN
//  done           out  1   1-cycle pulse when the count reaches 0
//  expired        out  1   high while state==DONE
// BEHAVIOUR
//  - Reset (async on reset==0):
//      state=IDLE, secs=START_SECS, presc=0.
//      display_value=START_SECS, running=0, done=0, expired=0.
//  - All outputs are registered. display_value==secs.
//  - Prescaler presc has $clog2(CLK_HZ) bits.
//      In RUN it counts 0..CLK_HZ-1 and wraps to 0.
//      tick = (state==RUN && presc==CLK_HZ-1).
//      Frozen in PAUSE, so the tick phase is kept across a pause.
//      Zeroed in IDLE and DONE, and on every start.
//  - FSM states IDLE, RUN, PAUSE, DONE. Per-cycle input priority: clear > start > pause.
//      clear        any state -> IDLE; secs=START_SECS; presc=0.
//      start        any state -> RUN; secs=START_SECS; presc=0. A start in RUN restarts the count.
//      pause        RUN -> PAUSE, PAUSE -> RUN. Ignored in IDLE and DONE.
//      tick, secs>1 secs <= secs-1; stay in RUN.
//      tick, secs==1 secs <= 0; state <= DONE; done=1 for exactly that next cycle.
//  - Latency:
//      First decrement occurs CLK_HZ cycles after the start pulse.
//      done rises on the same cycle display_value becomes 0.
//  - In DONE: display_value holds 0 and expired=1 until clear or start.
//  - A pause pulse on the same cycle as a tick:
//      The tick is applied first (secs decrements).
//      The FSM then enters PAUSE.
//      If that tick reached 0, DONE wins and the pause is dropped.
//  - secs never underflows; the RUN decrement is guarded by secs>=1.
//  - Reset asserted mid-count aborts immediately to the reset values.
// CONFIGURATION
//  Macro TIMER_BCD_OUT_EN.
//  - Defined:
//      Adds output port bcd_digits [15:0] = {thousands, hundreds, tens, ones}, 4 bits each.
//      Maintained as a parallel BCD down-counter: borrow ripples 0->9 across the digits.
//      Loaded with the BCD of START_SECS on reset, clear and start.
//      Always equal to the BCD of display_value, on every cycle.
//      Lets the downstream driver drop its /,% logic.
//  - Undefined:
//      Port and BCD counter are absent.
//      All other behaviour is identical.
// TESTING (bench: CLK_HZ=4, START_SECS=3)
//  1. Reset low, then high.
//       -> display_value=3; running=0; done=0; expired=0.
//  2. start pulse at cycle 0.
//       -> running=1 next cycle.
//       -> display_value 3->2->1->0 at cycles 5, 9, 13.
//       -> done=1 only at cycle 13; expired=1 from cycle 13.
//  3. start, then pause at cycle 2, then pause again at cycle 10.
//       -> value stays 3 during PAUSE; running=0 during PAUSE.
//       -> first decrement to 2 at cycle 13 (phase preserved).
//  4. clear and start on the same cycle mid-count.
//       -> IDLE; display_value=3; running=0.
//  5. In DONE, pulse start.
//       -> display_value=3; expired=0; running=1.
//       -> count repeats exactly as in test 2.
//  6. TIMER_BCD_OUT_EN defined, START_SECS=1000, count one tick.
//       -> bcd_digits goes 16'h1000 -> 16'h0999.

Source files
------------

// File: rtl/countdown_seconds_timer.sv
// Game countdown timer: divides clk to a 1 Hz tick and counts START_SECS down to 0.
// Optional macro TIMER_BCD_OUT_EN adds a parallel BCD down-counter on port bcd_digits.
module countdown_seconds_timer #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int START_SECS = 99
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [15:0] display_value,
  output logic        running,
  output logic        done,
  output logic        expired
`ifdef TIMER_BCD_OUT_EN
  ,
  output logic [15:0] bcd_digits
`endif
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [15:0]   START_VAL  = 16'(START_SECS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_r, state_nx_s;
  logic [15:0]   secs_r, secs_nx_s;
  logic [PW-1:0] presc_r, presc_nx_s;
  logic          done_r, done_nx_s;
  logic          running_r, expired_r;
  logic          tick_s;

  assign tick_s = (state_r == ST_RUN) && (presc_r == PRESC_MAX);

  // Next-state logic: clear > start > pause; a tick is applied before a same-cycle pause.
  always_comb begin
    state_nx_s = state_r;
    secs_nx_s  = secs_r;
    presc_nx_s = presc_r;
    done_nx_s  = 1'b0;
    if (clear) begin
      state_nx_s = ST_IDLE;
      secs_nx_s  = START_VAL;
      presc_nx_s = PRESC_ZERO;
    end else if (start) begin
      state_nx_s = ST_RUN;
      secs_nx_s  = START_VAL;
      presc_nx_s = PRESC_ZERO;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (tick_s) begin
            presc_nx_s = PRESC_ZERO;
            if (secs_r > 16'd1) begin
              secs_nx_s  = secs_r - 16'd1;
              state_nx_s = pause ? ST_PAUSE : ST_RUN;
            end else if (secs_r == 16'd1) begin
              // Reaching zero wins over a simultaneous pause.
              secs_nx_s  = 16'd0;
              state_nx_s = ST_DONE;
              done_nx_s  = 1'b1;
            end else begin
              state_nx_s = ST_DONE;
            end
          end else begin
            presc_nx_s = presc_r + PRESC_ONE;
            state_nx_s = pause ? ST_PAUSE : ST_RUN;
          end
        end
        ST_PAUSE: begin
          state_nx_s = pause ? ST_RUN : ST_PAUSE;
        end
        ST_IDLE, ST_DONE: begin
          presc_nx_s = PRESC_ZERO;
        end
        default: begin
          state_nx_s = ST_IDLE;
          secs_nx_s  = START_VAL;
          presc_nx_s = PRESC_ZERO;
        end
      endcase
    end
  end

  // State, count, prescaler and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      secs_r    <= START_VAL;
      presc_r   <= PRESC_ZERO;
      done_r    <= 1'b0;
      running_r <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      secs_r    <= secs_nx_s;
      presc_r   <= presc_nx_s;
      done_r    <= done_nx_s;
      running_r <= (state_nx_s == ST_RUN);
      expired_r <= (state_nx_s == ST_DONE);
    end
  end

  assign display_value = secs_r;
  assign running       = running_r;
  assign done          = done_r;
  assign expired       = expired_r;

`ifdef TIMER_BCD_OUT_EN
  localparam logic [15:0] START_BCD = {4'((START_SECS / 1000) % 10), 4'((START_SECS / 100) % 10),
                                       4'((START_SECS / 10) % 10), 4'(START_SECS % 10)};

  logic [15:0] bcd_r;
  logic        load_s, dec_s;

  // One BCD decrement; a zero digit becomes 9 and passes the borrow upward.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow && (r[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'd9;
      end else if (borrow) begin
        r[4*i +: 4] = r[4*i +: 4] - 4'd1;
        borrow      = 1'b0;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Mirror the binary counter's load and decrement events.
  always_comb begin
    load_s = clear || start;
    dec_s  = !clear && !start && tick_s && (secs_r != 16'd0);
  end

  // Parallel BCD down-counter tracking secs_r.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_r <= START_BCD;
    end else if (load_s) begin
      bcd_r <= START_BCD;
    end else if (dec_s) begin
      bcd_r <= bcd_dec(bcd_r);
    end else begin
      bcd_r <= bcd_r;
    end
  end

  assign bcd_digits = bcd_r;
`endif

endmodule

// File: tb/tb_countdown_seconds_timer.sv
// Scoreboard bench for countdown_seconds_timer: a behavioural model pushes expected
// outputs per cycle, an independent monitor pops and compares after each clock edge.
module tb_countdown_seconds_timer;

  localparam int CLK_HZ     = 4;
  localparam int START_SECS = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [15:0] display_value;
  logic        running, done, expired;

  typedef struct packed {
    logic [15:0] val;
    logic        run;
    logic        dn;
    logic        exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: a mode, seconds left, and cycles spent running within the current second.
  int   m_mode, m_secs, m_phase;
  logic m_done;

`ifdef TIMER_BCD_OUT_EN
  logic [15:0] bcd_digits;
  logic        big_start = 1'b0;
  logic [15:0] big_value, big_bcd;
  logic        big_running, big_done, big_expired;

  countdown_seconds_timer #(.CLK_HZ(CLK_HZ), .START_SECS(START_SECS)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .display_value(display_value), .running(running), .done(done), .expired(expired),
    .bcd_digits(bcd_digits));

  countdown_seconds_timer #(.CLK_HZ(CLK_HZ), .START_SECS(1000)) u_big (
    .clk(clk), .reset(reset), .start(big_start), .pause(1'b0), .clear(1'b0),
    .display_value(big_value), .running(big_running), .done(big_done), .expired(big_expired),
    .bcd_digits(big_bcd));
`else
  countdown_seconds_timer #(.CLK_HZ(CLK_HZ), .START_SECS(START_SECS)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .display_value(display_value), .running(running), .done(done), .expired(expired));
`endif

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_secs  = START_SECS;
    m_phase = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic s, input logic p);
    m_done = 1'b0;
    if (c) begin
      m_mode = M_IDLE; m_secs = START_SECS; m_phase = 0;
    end else if (s) begin
      m_mode = M_RUN; m_secs = START_SECS; m_phase = 0;
    end else if (m_mode == M_RUN) begin
      m_phase++;
      if (m_phase == CLK_HZ) begin
        m_phase = 0;
        m_secs--;
        if (m_secs == 0) begin
          m_mode = M_DONE;
          m_done = 1'b1;
        end
      end
      if (m_mode == M_RUN && p) m_mode = M_PAUSE;
    end else if (m_mode == M_PAUSE && p) begin
      m_mode = M_RUN;
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic c, input logic s, input logic p);
    exp_t e;
    @(negedge clk);
    reset = r; clear = c; start = s; pause = p;
    if (!r) model_reset();
    else model_step(c, s, p);
    e.val = 16'(m_secs);
    e.run = (m_mode == M_RUN);
    e.dn  = m_done;
    e.exp = (m_mode == M_DONE);
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({display_value, running, done, expired} !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t: got val=%0d run=%b done=%b exp=%b, required val=%0d run=%b done=%b exp=%b",
                   $time, display_value, running, done, expired, e.val, e.run, e.dn, e.exp);
        end
`ifdef TIMER_BCD_OUT_EN
        n_tests++;
        if (bcd_digits !== to_bcd(int'(e.val))) begin
          n_fail++;
          $display("FAIL bcd t=%0t: got %h, required %h", $time, bcd_digits, to_bcd(int'(e.val)));
        end
`endif
      end
    end
  end

  initial begin
    int guard;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    // Full count to zero, then restart from DONE.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (16) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (16) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    // Pause two cycles in, resume eight cycles later.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (7) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (16) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    // Pause on the exact tick cycle.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    // Clear and start together mid-count, then pause ignored in IDLE.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    // Reset mid-count.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    // Randomized traffic.
    repeat (3000) begin
      cyc(logic'($urandom_range(0, 499) != 0), logic'($urandom_range(0, 39) == 0),
          logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 11) == 0));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, required 0", exp_q.size());
    end
`ifdef TIMER_BCD_OUT_EN
    // Thousands boundary on a 1000-second instance.
    n_tests++;
    if (big_bcd !== 16'h1000) begin
      n_fail++;
      $display("FAIL big_load: got %h, required 1000", big_bcd);
    end
    @(negedge clk); big_start = 1'b1;
    @(negedge clk); big_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (big_bcd !== 16'h1000) begin
      n_fail++;
      $display("FAIL big_hold: got %h, required 1000", big_bcd);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (big_bcd !== 16'h0999 || big_value !== 16'd999) begin
      n_fail++;
      $display("FAIL big_tick: got %h/%0d, required 0999/999", big_bcd, big_value);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
